// File: rtl/move_sched_pkg.sv
// Shared FSM state encodings and move-code helpers for the move scheduler.
package move_sched_pkg;

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_ISSUE,
    MS_WAIT,
    MS_DONE,
    MS_FAIL
  } ms_state_t;

  localparam int unsigned NUM_MOVES = 12;
  localparam int unsigned INV_MASK  = 1;

  function automatic logic is_legal(input int unsigned code);
    return code < NUM_MOVES;
  endfunction

  // Inverse face turn: codes come in cw/ccw pairs differing in bit 0.
  function automatic int unsigned inverse(input int unsigned code);
    return code ^ INV_MASK;
  endfunction

endpackage

// File: rtl/move_sched_fifo.sv
// Synchronous move FIFO with push/pop/flush, tail read and tail pop.
module move_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    tail_pop,
  input  logic [CW-1:0]           din,
  output logic [CW-1:0]           head,
  output logic [CW-1:0]           tail,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] tail_ptr;

  assign tail_ptr = wr_ptr - AW'(1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // push and tail_pop are mutually exclusive: a cancelled move is never written.
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      else if (tail_pop)
        wr_ptr <= tail_ptr;
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop) - CNT_W'(tail_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/move_sched.sv
// Move scheduler: buffers predicted turns and issues them to the cube datapath.
// Build option MOVE_SCHED_CANCEL_EN: a move that inverts the FIFO tail cancels it.
module move_sched
  import move_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_STEPS = 10,
  parameter int unsigned CW        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [CW-1:0]          in_move,
  output logic                   in_ready,
  output logic                   cube_load,
  output logic [CW-1:0]          cube_move,
  input  logic                   cube_valid,
  input  logic                   cube_fin,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [3:0]             step_cnt,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [3:0]  MAX_CNT = 4'(MAX_STEPS);

  ms_state_t        state;
  logic [CNT_W-1:0] count;
  logic [CW-1:0]    head;
  logic [CW-1:0]    tail;
  logic             empty;
  logic             accept;
  logic             legal;
  logic             cancel;
  logic             push;
  logic             pop;
  logic             flush;
  logic             wait_hit;
  logic             finish;
  logic [3:0]       step_next;

  assign empty     = (count == '0);
  assign busy      = (state == MS_ISSUE) || (state == MS_WAIT);
  assign in_ready  = busy && (count < CNT_W'(DEPTH));
  assign occupancy = count;

  always_comb begin
    step_next = (step_cnt == 4'hF) ? step_cnt : step_cnt + 4'd1;
    wait_hit  = (state == MS_WAIT) && cube_valid;
    finish    = wait_hit && (cube_fin || (step_next == MAX_CNT));
    // Issue straight from WAIT on completion so the next load follows cube_valid by one cycle.
    pop       = !abort && !empty && ((state == MS_ISSUE) || (wait_hit && !finish));
    flush     = abort || finish;
    accept    = in_valid && in_ready;
    legal     = is_legal(32'(in_move));
  end

`ifdef MOVE_SCHED_CANCEL_EN
  // At occupancy 1 a same-cycle pop removes the tail, so there is nothing to cancel.
  assign cancel = accept && legal && !empty
                  && (tail == CW'(inverse(32'(in_move))))
                  && !((count == CNT_W'(1)) && pop);
`else
  logic unused_tail;
  assign cancel      = 1'b0;
  assign unused_tail = ^tail;
`endif

  assign push = accept && legal && !cancel && !abort;

  move_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .tail_pop (cancel),
    .din      (in_move),
    .head     (head),
    .tail     (tail),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MS_IDLE;
      cube_load <= 1'b0;
      cube_move <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
      step_cnt  <= '0;
    end else begin
      cube_load <= 1'b0;
      if (abort) begin
        state    <= MS_IDLE;
        done     <= 1'b0;
        fail     <= 1'b0;
        step_cnt <= '0;
      end else begin
        case (state)
          MS_IDLE, MS_DONE, MS_FAIL: begin
            if (start) begin
              state    <= MS_ISSUE;
              done     <= 1'b0;
              fail     <= 1'b0;
              step_cnt <= '0;
            end
          end
          MS_ISSUE: begin
            if (pop) begin
              cube_load <= 1'b1;
              cube_move <= head;
              state     <= MS_WAIT;
            end
          end
          MS_WAIT: begin
            if (wait_hit) begin
              step_cnt <= step_next;
              if (cube_fin) begin
                state <= MS_DONE;
                done  <= 1'b1;
              end else if (step_next == MAX_CNT) begin
                state <= MS_FAIL;
                fail  <= 1'b1;
              end else if (pop) begin
                cube_load <= 1'b1;
                cube_move <= head;
              end else begin
                state <= MS_ISSUE;
              end
            end
          end
          default: state <= MS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_sched.sv
// Self-checking bench for move_sched: queue-based reference model plus directed scenarios.
module tb_move_sched;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_STEPS = 10;
  localparam int unsigned CW        = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_move = '0;
  logic          in_ready;
  logic          cube_load;
  logic [CW-1:0] cube_move;
  logic          cube_valid = 1'b0;
  logic          cube_fin = 1'b0;
  logic          busy;
  logic          done;
  logic          fail;
  logic [3:0]    step_cnt;
  logic [2:0]    occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  move_sched #(
    .DEPTH     (DEPTH),
    .MAX_STEPS (MAX_STEPS),
    .CW        (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_move    (in_move),
    .in_ready   (in_ready),
    .cube_load  (cube_load),
    .cube_move  (cube_move),
    .cube_valid (cube_valid),
    .cube_fin   (cube_fin),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .step_cnt   (step_cnt),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  // Reference model: solve loop as a queue of pending moves and a few flags.
  logic [CW-1:0] q[$];
  bit            active = 0;
  bit            outstanding = 0;
  bit            solved = 0;
  bit            failed = 0;
  int            steps = 0;
  bit            e_load = 0;
  logic [CW-1:0] e_move = '0;

  always @(posedge clk or negedge rst_n) begin : model
    int pre;
    bit take, legal, cancel, issue, finish;
    if (!rst_n) begin
      q.delete();
      active = 0; outstanding = 0; solved = 0; failed = 0; steps = 0;
      e_load = 0; e_move = '0;
    end else begin
      pre    = q.size();
      take   = in_valid && active && (pre < DEPTH);
      legal  = (in_move < 12);
      e_load = 0;
      if (abort) begin
        q.delete();
        active = 0; outstanding = 0; solved = 0; failed = 0; steps = 0;
      end else begin
        finish = 0;
        issue  = 0;
        if (!active) begin
          if (start) begin
            active = 1; outstanding = 0; steps = 0; solved = 0; failed = 0;
          end
        end else begin
          if (outstanding && cube_valid) begin
            outstanding = 0;
            if (steps < 15) steps++;
            if (cube_fin) begin
              solved = 1; finish = 1;
            end else if (steps == MAX_STEPS) begin
              failed = 1; finish = 1;
            end
          end
          issue = !finish && !outstanding && (pre > 0);
        end
        cancel = 0;
`ifdef MOVE_SCHED_CANCEL_EN
        if (take && legal && pre > 0)
          cancel = ((in_move ^ 4'd1) == q[pre-1]) && !(pre == 1 && issue);
`endif
        if (issue) begin
          e_load = 1;
          e_move = q.pop_front();
          outstanding = 1;
        end
        if (cancel) void'(q.pop_back());
        else if (take && legal) q.push_back(in_move);
        if (finish) begin
          q.delete();
          active = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus a log of moves the cube received.
  logic [CW-1:0] loads[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("cube_load", cube_load, e_load);
      check("cube_move", cube_move, e_move);
      check("busy", busy, active);
      check("done", done, solved);
      check("fail", fail, failed);
      check("step_cnt", step_cnt, steps);
      check("occupancy", occupancy, q.size());
      check("in_ready", in_ready, active && (q.size() < DEPTH));
      if (cube_load) loads.push_back(cube_move);
    end
  end

  function automatic string seq();
    string s = "";
    foreach (loads[i]) s = {s, $sformatf("%0d ", loads[i])};
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; cyc(); abort = 1'b0;
  endtask

  task automatic pulse_valid(input bit fin);
    cube_valid = 1'b1; cube_fin = fin; cyc(); cube_valid = 1'b0; cube_fin = 1'b0;
  endtask

  task automatic push_move(input logic [CW-1:0] m);
    bit ok = 0;
    in_valid = 1'b1;
    in_move  = m;
    for (int k = 0; k < 80 && !ok; k++) begin
      ok = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic wait_load();
    bit seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      if (cube_load) seen = 1;
      else cyc();
    end
    if (!seen) check("load_timeout", 0, 1);
  endtask

  task automatic respond(input bit fin);
    wait_load();
    cyc();
    cyc();
    pulse_valid(fin);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_occ", occupancy, 0);
    check("rst_load", cube_load, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_step", step_cnt, 0);
    rst_n = 1'b1;
    cyc();

    // Three moves, solved on the third.
    loads.delete();
    pulse_start();
    fork
      begin push_move(3); push_move(7); push_move(0); end
      begin respond(0); respond(0); respond(1); end
    join
    cyc();
    check_str("t1_moves", seq(), "3 7 0 ");
    check("t1_step", step_cnt, 3);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);

    // Budget exhausted after ten steps.
    loads.delete();
    pulse_start();
    check("t2_done_cleared", done, 0);
    fork
      begin
        push_move(0); push_move(2); push_move(4); push_move(6); push_move(8);
        push_move(10); push_move(0); push_move(2); push_move(4); push_move(6);
      end
      begin
        for (int i = 0; i < 10; i++) respond(0);
      end
    join
    check("t2_fail", fail, 1);
    check("t2_step", step_cnt, 10);
    check("t2_in_ready", in_ready, 0);
    repeat (8) cyc();
    check_str("t2_moves", seq(), "0 2 4 6 8 10 0 2 4 6 ");

    // Fill FIFO while stalled, then abort.
    loads.delete();
    pulse_start();
    push_move(1);
    wait_load();
    push_move(2); push_move(4); push_move(6); push_move(8);
    check("t3_full_occ", occupancy, 4);
    check("t3_full_ready", in_ready, 0);
    pulse_valid(0);
    check("t3_pop_occ", occupancy, 3);
    check("t3_pop_load", cube_load, 1);
    check("t3_pop_ready", in_ready, 1);
    pulse_abort();
    check("t3_abort_occ", occupancy, 0);
    check("t3_abort_step", step_cnt, 0);
    check("t3_abort_busy", busy, 0);
    pulse_valid(0);
    check("t3_abort_load", cube_load, 0);
    cyc();
    check_str("t3_moves", seq(), "1 2 ");

    // Illegal code is swallowed.
    loads.delete();
    pulse_start();
    push_move(13);
    check("t4_occ", occupancy, 0);
    repeat (3) cyc();
    check("t4_loads", loads.size(), 0);
    pulse_abort();

    // Inverse pair pushed while stalled.
    loads.delete();
    pulse_start();
    push_move(9);
    wait_load();
    push_move(4);
    push_move(5);
`ifdef MOVE_SCHED_CANCEL_EN
    check("t5_occ", occupancy, 0);
    pulse_valid(0);
    repeat (3) cyc();
    check_str("t5_moves", seq(), "9 ");
    check("t5_busy", busy, 1);
    pulse_abort();
`else
    check("t5_occ", occupancy, 2);
    pulse_valid(0);
    respond(0);
    respond(1);
    cyc();
    check_str("t5_moves", seq(), "9 4 5 ");
    check("t5_done", done, 1);
    check("t5_step", step_cnt, 3);
`endif

    // Asynchronous reset mid-solve.
    pulse_start();
    push_move(11);
    wait_load();
    pulse_valid(0);
    push_move(6);
    wait_load();
    check("t6_pre_step", step_cnt, 1);
    check("t6_pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_step", step_cnt, 0);
    check("t6_rst_move", cube_move, 0);
    check("t6_rst_load", cube_load, 0);
    check("t6_rst_occ", occupancy, 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
